// File: rtl/edge_pkg.sv
// edge_pkg: shared state type and defaults for the edge-path blocks
package edge_pkg;
  typedef enum logic [1:0] {IDLE_LO, HOLD_LO, HOLD_HI, IDLE_HI} edge_state_e;
  localparam int CNT_W_DEF = 8;
endpackage

// File: rtl/edge_gen_if.sv
// edge_gen_if: request strobes in, generated level and status out
interface edge_gen_if;
  logic rise_req;
  logic down_req;
  logic a;
  logic ready;
  logic pend;
  logic err;
  modport master (output rise_req, down_req, input a, ready, pend, err);
  modport slave (input rise_req, down_req, output a, ready, pend, err);
endinterface

// File: rtl/edge_gen_dwell_timer.sv
// dwell_timer: loadable down-counter that parks at zero and flags it
module dwell_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] val_i,
  output logic             zero_o
);
  logic [CNT_W-1:0] cnt_q;
  assign zero_o = cnt_q == '0;
  // load wins over counting; the count holds once it reaches zero
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= load_i ? val_i : zero_o ? cnt_q : cnt_q - CNT_W'(1);
endmodule

// File: rtl/edge_gen.sv
// edge_gen: turns rise/down strobes into a level with minimum high/low dwell
module edge_gen
  import edge_pkg::*;
#(
  parameter int MIN_HIGH = 3,
  parameter int MIN_LOW  = 2,
  parameter int CNT_W    = CNT_W_DEF
) (
  input logic        clk,
  input logic        rst_n,
  edge_gen_if.slave  bus
);
  edge_state_e      state_q, state_d;
  logic             a_q, a_d, pend_q, pend_d, err_q, err_d;
  logic             both, opp, same, pend_eff, hold, toggle, cnt_zero;
  logic [CNT_W-1:0] load_val;

  dwell_timer #(.CNT_W(CNT_W)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (toggle),
    .val_i  (load_val),
    .zero_o (cnt_zero)
  );

  // classify the request against the current level, then decide toggle/queue/cancel
  always_comb begin
    both     = bus.rise_req & bus.down_req;
    opp      = ~both & (a_q ? bus.down_req : bus.rise_req);
    same     = ~both & (a_q ? bus.rise_req : bus.down_req);
    pend_eff = pend_q & ~same;
    hold     = state_q == HOLD_LO || state_q == HOLD_HI;
    toggle   = hold ? cnt_zero & (pend_eff | opp) : opp;
    a_d      = a_q ^ toggle;
    state_d  = toggle ? (a_q ? HOLD_LO : HOLD_HI)
             : (hold & cnt_zero) ? (a_q ? IDLE_HI : IDLE_LO) : state_q;
    pend_d   = ~toggle & (pend_eff | (hold & opp));
    err_d    = both | (same & ~pend_q);
    load_val = a_q ? CNT_W'(MIN_LOW - 1) : CNT_W'(MIN_HIGH - 1);
  end

  // state, level, pending flag and error pulse registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE_LO;
      a_q     <= 1'b0;
      pend_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      pend_q  <= pend_d;
      err_q   <= err_d;
    end

  assign bus.a     = a_q;
  assign bus.pend  = pend_q;
  assign bus.err   = err_q;
  assign bus.ready = state_q == IDLE_LO || state_q == IDLE_HI;
endmodule
